// File: rtl/mux_pkg.sv
// Shared types and default sizing for the mux select arbiter.
package mux_pkg;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  localparam int MUX_DATA_W    = 2;
  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/burst_rr_pick.sv
// Combinational winner pick: a lone requester always wins; under contention the
// owner keeps the grant until its burst count reaches MAX_BURST.
module burst_rr_pick
  import mux_pkg::*;
#(
  parameter int MAX_BURST = ARB_MAX_BURST,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             a_valid,
  input  logic             b_valid,
  input  src_e             owner,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             winner_vld,
  output src_e             winner
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  src_e non_owner;

  always_comb begin
    non_owner  = (owner == SRC_A) ? SRC_B : SRC_A;
    winner_vld = a_valid || b_valid;
    winner     = SRC_A;
    if (a_valid && b_valid) begin
      winner = (burst_cnt < MAX_CNT) ? owner : non_owner;
    end else if (b_valid) begin
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-source burst-limited round-robin arbiter feeding a single-entry output
// register; the registered sel steers the downstream 2:1 data mux.
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W    = MUX_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  src_e              sel_q,       sel_d;
  src_e              owner_q,     owner_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              load_en;
  logic              winner_vld;
  src_e              winner;

  burst_rr_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .owner      (owner_q),
    .burst_cnt  (cnt_q),
    .winner_vld (winner_vld),
    .winner     (winner)
  );

  assign load_en = !out_valid_q || out_ready;
  assign a_ready = load_en && winner_vld && (winner == SRC_A);
  assign b_ready = load_en && winner_vld && (winner == SRC_B);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    if (load_en) begin
      if (winner_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = (winner == SRC_B) ? b_data : a_data;
        sel_d       = winner;
        if (winner == owner_q) begin
          // Count saturates so a lone requester can stream indefinitely.
          cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + ONE_CNT;
        end else begin
          owner_d = winner;
          cnt_d   = ONE_CNT;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= SRC_A;
      owner_q     <= SRC_A;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-input burst-limited round-robin arbiter that sits directly upstream of the 2:1 data mux (`MUX_gate`). It accepts beats from two valid/ready sources, selects one per cycle, registers the winning beat, and drives the registered `sel` for the downstream mux. Its output stage is a single register with valid/ready flow control. The block limits consecutive grants to one source so that neither source is starved.

## Interface
- `DATA_W`, default 2: beat width; matches the mux data width.
- `MAX_BURST`, default 4: maximum consecutive beats granted to one source while the other source is requesting. Legal range is 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_valid` in 1: source A has a beat.
- `a_data` in DATA_W: source A beat.
- `a_ready` out 1: source A beat is accepted this cycle.
- `b_valid` in 1: source B has a beat.
- `b_data` in DATA_W: source B beat.
- `b_ready` out 1: source B beat is accepted this cycle.
- `out_valid` out 1: the output register holds a beat.
- `out_data` out DATA_W: registered beat.
- `out_ready` in 1: downstream accepts the beat.
- `sel` out 1: source of the registered beat (0 = A, 1 = B); drives the mux select.

## Operation
- `load_en = !out_valid || out_ready`. This is a single-entry pipe register with full throughput of 1 beat/cycle.
- Owner FSM has two states, OWN_A and OWN_B, plus `burst_cnt` (width `$clog2(MAX_BURST+1)`, saturating at MAX_BURST).
- Winner selection (combinational):
  - Only one source valid: that source wins.
  - Both valid: the owner wins if `burst_cnt < MAX_BURST`; otherwise the non-owner wins.
  - Neither valid: no winner.
- `a_ready = load_en && winner==A`; `b_ready = load_en && winner==B`. At most one ready is high per cycle. Ready depends combinationally on `out_ready` and both valids.
- On transfer, i.e. `load_en` and a winner exists:
  - `out_data <= winner data`, `sel <= winner`, `out_valid <= 1`.
  - If winner == owner: `burst_cnt <= min(burst_cnt+1, MAX_BURST)`.
  - Otherwise: the owner switches to the winner and `burst_cnt <= 1`.
- `load_en` with no winner: `out_valid <= 0`. `out_data`, `sel`, owner and `burst_cnt` hold.
- No `load_en`: all state holds. `out_data` and `sel` are stable while `out_valid && !out_ready`.
- A lone requester is never throttled by `burst_cnt`. It streams indefinitely and the count saturates.
- Once the count has saturated, an idle cycle (no winner) does not clear `burst_cnt`; only an ownership change does.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `sel`=0, owner=OWN_A, `burst_cnt`=0. `a_ready`/`b_ready` follow from these values: high when the matching valid is high.
- Reset assertion takes effect immediately, asynchronously. An in-flight beat in the output register is discarded, not delivered. Deassertion is synchronized externally.
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data`/`sel` after edge N, i.e. 1 cycle.
- Simultaneous downstream pop and upstream push in the same cycle is legal and yields back-to-back beats with no bubble.
- `sel` changes only on a transfer edge. It is never combinational from inputs.

## Structure
- Shared package `mux_pkg` holds:
  - typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} `src_e`, used for `sel`, owner and winner.
  - Default localparams `MUX_DATA_W=2` and `ARB_MAX_BURST=4`.
- One natural combinational sub-module, `burst_rr_pick`. It takes `a_valid`, `b_valid`, owner and `burst_cnt`, and returns `winner_vld` and `winner`.
- The top level holds the owner/count registers and the output register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`=0, `sel`=0, `out_data`=0 immediately. The first post-reset beat with both sources valid is taken from A.
- **Single source:** MAX_BURST=2, A only, `a_data`=2'b01, `out_ready`=1, 6 cycles → 6 consecutive A beats at 1/cycle. `sel`=0 throughout; `b_ready` never asserts.
- **Contention:** MAX_BURST=2, both valid continuously, `a_data`=2'b01, `b_data`=2'b10, `out_ready`=1 → output sequence A,A,B,B,A,A; `sel` sequence 0,0,1,1,0,0.
- **Backpressure:** beat 2'b11 from B held with `out_ready`=0 for 5 cycles → `a_ready`=`b_ready`=0, `out_data`=2'b11 and `sel`=1 stable. When `out_ready` is raised, the next beat loads on the same edge.
- **Bubble:** both sources drop valid for 1 cycle with `out_ready`=1 → `out_valid`=0 for exactly one cycle. Owner and count are preserved; a B-owned burst of 1 continues with B next when both are valid.
- **MAX_BURST=1 with both valid:** output strictly alternates A,B,A,B. Every accepted beat is bit-exact against a scoreboard of per-source in-order queues.
